// File: rtl/alu_sequencer.sv
// Sequencer for an adiabatic ALU driven by a Bennett clock. It latches an operation,
// waits for the instruction edges and the phase peak, and returns the zero flag.
module alu_sequencer #(
    parameter int unsigned WIDTH   = 13,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic             req_a_sel,
    input  logic [1:0]       req_b_sel,
    input  logic [1:0]       req_out_sel,
    input  logic             instFlag,
    input  logic [WIDTH-1:0] clkpos,
    input  logic [WIDTH-1:0] clkneg,
    input  logic             zero_in,
    output logic             ALU_Control0,
    output logic             ALU_Control1,
    output logic             A_mux,
    output logic             B_mux0,
    output logic             B_mux1,
    output logic             SUB,
    output logic             STL,
    output logic             Adder_Cin,
    output logic             mux3_0,
    output logic             mux3_1,
    output logic             ALU_O_Fclkpos,
    output logic             A_Fclkpos,
    output logic             busy,
    output logic             done,
    output logic             zero_out,
    output logic             timeout
);

    localparam int unsigned CNT_W = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARM     = 3'd1,
        EVAL    = 3'd2,
        CAPTURE = 3'd3,
        SETTLE  = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] wait_cnt;
    logic             inst_q;
    logic             inst_rise;
    logic             peak;
    logic             accept;
    logic             wait_expired;
    logic             abort;
    logic             finish;
    logic [4:0]       op_ctrl;

    assign inst_rise    = instFlag & ~inst_q;
    assign peak         = (&clkpos) & ~(|clkneg);
    assign accept       = (state_q == IDLE) & req_valid;
    // Abort on the edge where the count would reach TIMEOUT.
    assign wait_expired = (CNT_W'(wait_cnt + CNT_W'(1)) == CNT_W'(TIMEOUT));

    // Next-state logic; peak is checked before any other EVAL exit.
    always_comb begin
        state_d = state_q;
        abort   = 1'b0;
        finish  = 1'b0;
        case (state_q)
            IDLE:    if (req_valid) state_d = ARM;
            ARM: begin
                if (inst_rise) begin
                    state_d = EVAL;
                end else if (wait_expired) begin
                    state_d = DONE;
                    abort   = 1'b1;
                end
            end
            EVAL: begin
                if (peak) begin
                    state_d = CAPTURE;
                end else if (wait_expired) begin
                    state_d = DONE;
                    abort   = 1'b1;
                end
            end
            CAPTURE: state_d = SETTLE;
            SETTLE: begin
                if (inst_rise) begin
                    state_d = DONE;
                    finish  = 1'b1;
                end else if (wait_expired) begin
                    state_d = DONE;
                    abort   = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // {ALU_Control1, ALU_Control0, SUB, Adder_Cin, STL}; illegal opcodes decode as ADD.
    always_comb begin
        op_ctrl = 5'b10_0_0_0;
        case (req_op)
            3'b001:  op_ctrl = 5'b10_1_1_0;
            3'b010:  op_ctrl = 5'b00_0_0_0;
            3'b011:  op_ctrl = 5'b01_0_0_0;
            3'b100:  op_ctrl = 5'b10_1_1_1;
            3'b101:  op_ctrl = 5'b11_0_0_0;
            default: op_ctrl = 5'b10_0_0_0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inst_q   <= 1'b0;
            wait_cnt <= '0;
        end else begin
            inst_q <= instFlag;
            if (state_d != state_q)
                wait_cnt <= '0;
            else if (state_q == ARM || state_q == EVAL || state_q == SETTLE)
                wait_cnt <= CNT_W'(wait_cnt + CNT_W'(1));
        end
    end

    // Control lines only move on the accept edge so evaluation sees stable values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            {ALU_Control1, ALU_Control0, SUB, Adder_Cin, STL} <= '0;
            {A_mux, B_mux1, B_mux0, mux3_1, mux3_0}           <= '0;
        end else if (accept) begin
            {ALU_Control1, ALU_Control0, SUB, Adder_Cin, STL} <= op_ctrl;
            {A_mux, B_mux1, B_mux0, mux3_1, mux3_0} <= {req_a_sel, req_b_sel, req_out_sel};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_ready     <= 1'b1;
            busy          <= 1'b0;
            done          <= 1'b0;
            ALU_O_Fclkpos <= 1'b0;
            A_Fclkpos     <= 1'b0;
            zero_out      <= 1'b0;
            timeout       <= 1'b0;
        end else begin
            req_ready     <= (state_d == IDLE);
            busy          <= (state_d != IDLE);
            done          <= (state_d == DONE);
            ALU_O_Fclkpos <= (state_d == CAPTURE);
            A_Fclkpos     <= (state_d == CAPTURE);
            if (finish)
                zero_out <= zero_in;
            if (accept)
                timeout <= 1'b0;
            else if (abort)
                timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: a vector table, directed corner cases and
// random transactions, each predicted from per-cycle stimulus arrays.
module tb_alu_sequencer;

    localparam int unsigned WIDTH = 13;
    localparam int MAXC = 800;
    localparam int TMO  = 255;

    logic             clk = 1'b0;
    logic             reset;
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_op;
    logic             req_a_sel;
    logic [1:0]       req_b_sel;
    logic [1:0]       req_out_sel;
    logic             instFlag;
    logic [WIDTH-1:0] clkpos;
    logic [WIDTH-1:0] clkneg;
    logic             zero_in;
    logic             ALU_Control0, ALU_Control1, A_mux, B_mux0, B_mux1;
    logic             SUB, STL, Adder_Cin, mux3_0, mux3_1;
    logic             ALU_O_Fclkpos, A_Fclkpos, busy, done, zero_out, timeout;

    alu_sequencer #(.WIDTH(WIDTH), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a_sel(req_a_sel), .req_b_sel(req_b_sel),
        .req_out_sel(req_out_sel), .instFlag(instFlag), .clkpos(clkpos),
        .clkneg(clkneg), .zero_in(zero_in), .ALU_Control0(ALU_Control0),
        .ALU_Control1(ALU_Control1), .A_mux(A_mux), .B_mux0(B_mux0),
        .B_mux1(B_mux1), .SUB(SUB), .STL(STL), .Adder_Cin(Adder_Cin),
        .mux3_0(mux3_0), .mux3_1(mux3_1), .ALU_O_Fclkpos(ALU_O_Fclkpos),
        .A_Fclkpos(A_Fclkpos), .busy(busy), .done(done), .zero_out(zero_out),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    logic [9:0] ctrl;
    logic [6:0] status;
    assign ctrl   = {ALU_Control1, ALU_Control0, SUB, Adder_Cin, STL,
                     A_mux, B_mux1, B_mux0, mux3_1, mux3_0};
    assign status = {busy, req_ready, done, ALU_O_Fclkpos, A_Fclkpos, timeout, zero_out};

    int   checks = 0;
    int   errors = 0;
    logic exp_zero = 1'b0;

    // Index k holds the value sampled by the DUT at the k-th edge after accept.
    logic inst_a [MAXC];
    logic pk_a   [MAXC];
    logic zin_a  [MAXC];

    typedef struct {
        logic [2:0] op;
        logic       a;
        logic [1:0] b;
        logic [1:0] o;
        logic [4:0] exp_op;
        int         mode;
    } vec_t;

    vec_t       vecs [8];
    logic [4:0] exp_tab [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input int k);
        instFlag = inst_a[k];
        zero_in  = zin_a[k];
        if (pk_a[k]) begin
            clkpos = '1;
            clkneg = '0;
        end else if ($urandom_range(0, 3) == 0) begin
            clkpos = '1;
            clkneg = WIDTH'(1) << $urandom_range(0, WIDTH - 1);
        end else begin
            clkpos = WIDTH'($urandom);
            clkneg = WIDTH'($urandom);
            if ((&clkpos) && clkneg == '0) clkneg = WIDTH'(1);
        end
    endtask

    function automatic bit rise(input int k);
        return inst_a[k] && !inst_a[k-1];
    endfunction

    // mode 0 random, 1 no instFlag, 2 zero_in stuck 1, 3 no peak, 4 slow instFlag
    task automatic run_txn(input logic [2:0] op, input logic a, input logic [1:0] b,
                           input logic [1:0] o, input logic [4:0] exp_op,
                           input int mode, input bit hold);
        int         a_k, p_k, d_k;
        bit         ab;
        logic [9:0] exp_ctrl;
        logic       z_e, f_e, bz_e;
        for (int k = 0; k < MAXC; k++) begin
            inst_a[k] = ($urandom_range(0, 2) == 0);
            pk_a[k]   = ($urandom_range(0, 4) == 0);
            zin_a[k]  = 1'($urandom);
            case (mode)
                1: inst_a[k] = 1'b0;
                2: zin_a[k]  = 1'b1;
                3: pk_a[k]   = 1'b0;
                4: begin
                    inst_a[k] = ((k / 37) % 2) == 1;
                    pk_a[k]   = ($urandom_range(0, 19) == 0);
                end
                default: ;
            endcase
        end
        // Reference: first rise within TMO cycles of ARM, first peak within TMO of EVAL,
        // one CAPTURE cycle, first rise within TMO of SETTLE.
        a_k = -1; p_k = -1; d_k = -1; ab = 1'b0;
        for (int k = 1; k <= TMO; k++) if (rise(k)) begin a_k = k; break; end
        if (a_k < 0) begin
            d_k = TMO; ab = 1'b1;
        end else begin
            for (int k = a_k + 1; k <= a_k + TMO; k++) if (pk_a[k]) begin p_k = k; break; end
            if (p_k < 0) begin
                d_k = a_k + TMO; ab = 1'b1;
            end else begin
                for (int k = p_k + 2; k <= p_k + 1 + TMO; k++) if (rise(k)) begin d_k = k; break; end
                if (d_k < 0) begin d_k = p_k + 1 + TMO; ab = 1'b1; end
            end
        end
        exp_ctrl    = {exp_op, a, b, o};
        req_op      = op;
        req_a_sel   = a;
        req_b_sel   = b;
        req_out_sel = o;
        req_valid   = 1'b1;
        drive(0);
        @(posedge clk); #1;
        if (!hold) req_valid = 1'b0;
        for (int k = 0; k <= d_k + 1; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            bz_e = (k <= d_k);
            f_e  = (p_k >= 0) && (k == p_k);
            z_e  = (k >= d_k && !ab) ? zin_a[d_k] : exp_zero;
            chk($sformatf("ctrl op%0d k%0d", op, k), 32'(ctrl), 32'(exp_ctrl));
            chk($sformatf("status op%0d k%0d", op, k), 32'(status),
                32'({bz_e, !bz_e, k == d_k, f_e, f_e, (k >= d_k) && ab, z_e}));
            drive(k + 1);
        end
        if (!ab) exp_zero = zin_a[d_k];
    endtask

    initial begin
        vecs[0] = '{3'b000, 1'b1, 2'b11, 2'b00, 5'b10000, 0};
        vecs[1] = '{3'b100, 1'b0, 2'b01, 2'b10, 5'b10111, 4};
        vecs[2] = '{3'b001, 1'b1, 2'b10, 2'b01, 5'b10110, 0};
        vecs[3] = '{3'b010, 1'b0, 2'b00, 2'b11, 5'b00000, 2};
        vecs[4] = '{3'b011, 1'b1, 2'b01, 2'b00, 5'b01000, 0};
        vecs[5] = '{3'b101, 1'b0, 2'b10, 2'b10, 5'b11000, 0};
        vecs[6] = '{3'b111, 1'b1, 2'b11, 2'b00, 5'b10000, 2};
        vecs[7] = '{3'b110, 1'b0, 2'b01, 2'b01, 5'b10000, 0};
        exp_tab = '{5'b10000, 5'b10110, 5'b00000, 5'b01000,
                    5'b10111, 5'b11000, 5'b10000, 5'b10000};

        reset = 1'b0; req_valid = 1'b0; req_op = '0; req_a_sel = 1'b0;
        req_b_sel = '0; req_out_sel = '0; instFlag = 1'b0; clkpos = '0;
        clkneg = '0; zero_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ctrl", 32'(ctrl), 32'd0);
        chk("reset_status", 32'(status), 32'(7'b0100000));
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        foreach (vecs[i])
            run_txn(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].o, vecs[i].exp_op, vecs[i].mode, 1'b0);

        run_txn(3'b000, 1'b0, 2'b00, 2'b00, 5'b10000, 1, 1'b0);
        run_txn(3'b011, 1'b1, 2'b11, 2'b11, 5'b01000, 0, 1'b0);
        run_txn(3'b001, 1'b0, 2'b10, 2'b01, 5'b10110, 3, 1'b0);

        run_txn(3'b010, 1'b1, 2'b01, 2'b10, 5'b00000, 0, 1'b1);
        run_txn(3'b101, 1'b0, 2'b10, 2'b01, 5'b11000, 0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            logic [2:0] rop;
            rop = 3'($urandom);
            run_txn(rop, 1'($urandom), 2'($urandom), 2'($urandom), exp_tab[rop],
                    ($urandom_range(0, 3) == 0) ? 2 : 0, 1'($urandom));
        end
        req_valid = 1'b0;
        @(posedge clk); #1;

        // Reset during EVAL drops the operation with no done or capture afterward.
        req_op = 3'b100; req_a_sel = 1'b1; req_b_sel = 2'b11; req_out_sel = 2'b01;
        req_valid = 1'b1; instFlag = 1'b0; clkpos = '0; clkneg = '0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        instFlag = 1'b1;
        @(posedge clk); #1;
        chk("pre_reset_busy", 32'(busy), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("midop_reset_ctrl", 32'(ctrl), 32'd0);
        chk("midop_reset_status", 32'(status), 32'(7'b0100000));
        @(posedge clk); #3;
        reset = 1'b1;
        for (int n = 0; n < 30; n++) begin
            instFlag = 1'(n % 3 == 0);
            clkpos   = (n % 4 == 1) ? '1 : WIDTH'($urandom);
            clkneg   = (n % 4 == 1) ? '0 : WIDTH'($urandom);
            @(posedge clk); #1;
            chk($sformatf("post_reset_status n%0d", n), 32'(status), 32'(7'b0100000));
            chk($sformatf("post_reset_ctrl n%0d", n), 32'(ctrl), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
